tile_match_engine: RTL and testbench
====================================

# tile_match_engine

Parametrised game core for the FPGA tile-matching game. It replaces the fixed 10-tile in-game FSM with a generalised engine: N tiles, a per-game colour table, edge-detected selection, a timed mismatch reveal, and a saturating move counter. It sits between the top-level menu FSM (which drives `inGameOn` and `userquit`) and the LED/HEX display drivers.

## Interface
Parameters:
- NUM_TILES, 10: tile count. Must be even and ≥ 2.
- COLOR_W, 3: bits per tile colour.
- SCORE_W, 8: width of the move counter.
- REVEAL_CYCLES, 100000000: cycles a mismatched pair stays shown. Must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- inGameOn  in  1  game enabled by the menu FSM.
- userquit  in  1  quit request; level-sensitive.
- selectSW  in  1  debounced select button; a falling edge is one select event.
- SW  in  NUM_TILES  tile choice switches.
- tileColors  in  NUM_TILES*COLOR_W  colour of tile i at [i*COLOR_W +: COLOR_W].
- ledMask  out  NUM_TILES  matched tiles OR currently selected tiles.
- matchedMask  out  NUM_TILES  tiles permanently matched.
- color1, color2  out  COLOR_W each  colours of the first and second pick.
- color1Valid, color2Valid  out  1 each  the corresponding colour is being shown.
- mismatch  out  1  high while in REVEAL.
- moves  out  SCORE_W  pair attempts; saturates at all-ones.
- gameOver  out  1  all tiles matched.

## Operation
- States: NOT_IN_GAME, IDLE, ONE_TILE, TWO_TILE, REVEAL, GAME_OVER.
- Reset forces NOT_IN_GAME and clears every output and internal register to 0.
- Select event (`sel`):
  - Two-stage register s1←selectSW, s2←s1.
  - `sel` = s2 & ~s1.
  - Both stages reset to 0.
- Pick rule: on `sel`, choose the lowest index i with SW[i]=1, matched[i]=0, and i ≠ first pick. If no index qualifies, the event is ignored with no state change.
- NOT_IN_GAME:
  - Holds all outputs cleared.
  - When inGameOn=1, latch tileColors into an internal table, clear matched, moves, and gameOver, and go to IDLE.
- Abort: in IDLE, ONE_TILE, TWO_TILE, or REVEAL, userquit=1 or inGameOn=0 goes to NOT_IN_GAME. Abort takes priority over `sel` and over reveal expiry.
- IDLE: a valid pick stores idx1 and color1, sets color1Valid, and goes to ONE_TILE.
- ONE_TILE: a valid pick stores idx2 and color2, sets color2Valid, and goes to TWO_TILE.
- TWO_TILE: on `sel`, regardless of SW, moves ← moves+1, saturating.
  - Match (color1 == color2):
    - Set matched[idx1] and matched[idx2].
    - Clear both picks and both valid flags.
    - If the updated mask is all ones, go to GAME_OVER; otherwise go to IDLE.
  - Mismatch: load the reveal counter with REVEAL_CYCLES-1, assert mismatch, and go to REVEAL.
- REVEAL:
  - Picks stay displayed; further `sel` events are ignored.
  - When the counter reaches 0: clear picks and valid flags, deassert mismatch, and go to IDLE.
- GAME_OVER:
  - gameOver=1, ledMask=0, valid flags=0; moves is held.
  - userquit=1 or inGameOn=0 goes to NOT_IN_GAME.
- ledMask = matched | (color1Valid ? onehot(idx1) : 0) | (color2Valid ? onehot(idx2) : 0). In GAME_OVER it is forced to 0.

## Timing
- All outputs are registered.
- Select latency:
  - selectSW falls before edge k, so s1=0 after k.
  - `sel` is high between k and k+1.
  - State and outputs update at edge k+1.
  - A press is therefore 2 clock edges from pin to output.
- One `sel` pulse is produced per falling edge. A held-low button does not repeat.
- Reveal: exactly REVEAL_CYCLES cycles in REVEAL, counted from the TWO_TILE exit edge to the IDLE entry edge.
- gameOver asserts on the same edge that the final matched bits set.
- Reset mid-reveal or mid-pick returns to NOT_IN_GAME immediately (asynchronous). The first valid state is one edge after reset deasserts.
- Abort response: the next edge after userquit is sampled high.

## Test plan
Configuration for all scenarios: NUM_TILES=10, COLOR_W=3, REVEAL_CYCLES=4, and colours for tiles 0..9 = 1,2,3,4,2,4,3,1,5,5.
1. Match: inGameOn=1, pick SW[0] then SW[7], then press select. Result: matchedMask=10'h081, moves=1, state IDLE, ledMask=10'h081.
2. Mismatch reveal: pick tiles 0 and 1, then select.
   - mismatch=1 for exactly 4 cycles with ledMask=10'h003.
   - Then ledMask=0, valid flags=0, moves=1.
   - Select presses during the reveal leave moves=1.
3. Invalid pick: after tiles 0 and 7 are matched, SW=10'h081 plus a press gives no state change. SW=10'h083 picks tile 1.
4. Game over: match all five pairs in 5 attempts. Result: gameOver=1 on the final-match edge, moves=5, ledMask=0. Dropping inGameOn then leads to NOT_IN_GAME with all outputs 0.
5. Abort: in ONE_TILE, assert userquit. Next edge: NOT_IN_GAME, color1Valid=0, moves=0.
6. Saturation and reset: with SCORE_W=2, make 5 mismatched attempts and check moves=3. Assert reset mid-REVEAL: all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/tile_match_engine.sv
// tile_match_engine: parametrised tile-matching game core.
// Ports: CLOCK_50/reset (async, active-high); inGameOn/userquit from the
// menu FSM; selectSW (falling edge = select) and SW pick a tile; tileColors
// is the per-game colour table; ledMask/matchedMask/color1/color2/
// color1Valid/color2Valid/mismatch/moves/gameOver drive the displays.
module tile_match_engine #(
    parameter int NUM_TILES     = 10,
    parameter int COLOR_W       = 3,
    parameter int SCORE_W       = 8,
    parameter int REVEAL_CYCLES = 100000000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         inGameOn,
    input  logic                         userquit,
    input  logic                         selectSW,
    input  logic [NUM_TILES-1:0]         SW,
    input  logic [NUM_TILES*COLOR_W-1:0] tileColors,
    output logic [NUM_TILES-1:0]         ledMask,
    output logic [NUM_TILES-1:0]         matchedMask,
    output logic [COLOR_W-1:0]           color1,
    output logic [COLOR_W-1:0]           color2,
    output logic                         color1Valid,
    output logic                         color2Valid,
    output logic                         mismatch,
    output logic [SCORE_W-1:0]           moves,
    output logic                         gameOver
);

    localparam int IDX_W = (NUM_TILES > 2) ? $clog2(NUM_TILES) : 1;
    localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REV_LOAD = CNT_W'(REVEAL_CYCLES - 1);

    typedef enum logic [2:0] {
        NOT_IN_GAME,
        IDLE,
        ONE_TILE,
        TWO_TILE,
        REVEAL,
        GAME_OVER
    } state_t;

    state_t                       state;
    logic                         s1;
    logic                         s2;
    logic [NUM_TILES*COLOR_W-1:0] color_tab;
    logic [IDX_W-1:0]             idx1;
    logic [IDX_W-1:0]             idx2;
    logic [CNT_W-1:0]             rev_cnt;

    logic                         sel;
    logic                         abort;
    logic [NUM_TILES-1:0]         oh1;
    logic [NUM_TILES-1:0]         oh2;
    logic [NUM_TILES-1:0]         excl;
    logic [NUM_TILES-1:0]         cand;
    logic [NUM_TILES-1:0]         new_matched;
    logic                         pick_ok;
    logic [IDX_W-1:0]             pick_idx;
    logic [COLOR_W-1:0]           pick_color;

    assign sel         = s2 & ~s1;
    assign abort       = userquit | ~inGameOn;
    assign oh1         = NUM_TILES'(1) << idx1;
    assign oh2         = NUM_TILES'(1) << idx2;
    // The first pick may not be chosen again as the second pick.
    assign excl        = (state == ONE_TILE) ? oh1 : '0;
    assign cand        = SW & ~matchedMask & ~excl;
    assign new_matched = matchedMask | oh1 | oh2;
    assign pick_color  = color_tab[pick_idx*COLOR_W +: COLOR_W];

    // Lowest qualifying index wins: scan downward so the last hit is lowest.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_ok  = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= NOT_IN_GAME;
            s1          <= 1'b0;
            s2          <= 1'b0;
            color_tab   <= '0;
            idx1        <= '0;
            idx2        <= '0;
            rev_cnt     <= '0;
            ledMask     <= '0;
            matchedMask <= '0;
            color1      <= '0;
            color2      <= '0;
            color1Valid <= 1'b0;
            color2Valid <= 1'b0;
            mismatch    <= 1'b0;
            moves       <= '0;
            gameOver    <= 1'b0;
        end else begin
            s1 <= selectSW;
            s2 <= s1;
            if (state != NOT_IN_GAME && abort) begin
                // Leaving the game clears everything the displays see.
                state       <= NOT_IN_GAME;
                idx1        <= '0;
                idx2        <= '0;
                rev_cnt     <= '0;
                ledMask     <= '0;
                matchedMask <= '0;
                color1      <= '0;
                color2      <= '0;
                color1Valid <= 1'b0;
                color2Valid <= 1'b0;
                mismatch    <= 1'b0;
                moves       <= '0;
                gameOver    <= 1'b0;
            end else begin
                unique case (state)
                    NOT_IN_GAME: begin
                        if (inGameOn) begin
                            color_tab   <= tileColors;
                            matchedMask <= '0;
                            moves       <= '0;
                            gameOver    <= 1'b0;
                            ledMask     <= '0;
                            state       <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (sel && pick_ok) begin
                            idx1        <= pick_idx;
                            color1      <= pick_color;
                            color1Valid <= 1'b1;
                            ledMask     <= ledMask | (NUM_TILES'(1) << pick_idx);
                            state       <= ONE_TILE;
                        end
                    end
                    ONE_TILE: begin
                        if (sel && pick_ok) begin
                            idx2        <= pick_idx;
                            color2      <= pick_color;
                            color2Valid <= 1'b1;
                            ledMask     <= ledMask | (NUM_TILES'(1) << pick_idx);
                            state       <= TWO_TILE;
                        end
                    end
                    TWO_TILE: begin
                        if (sel) begin
                            if (moves != '1)
                                moves <= moves + SCORE_W'(1);
                            if (color1 == color2) begin
                                matchedMask <= new_matched;
                                idx1        <= '0;
                                idx2        <= '0;
                                color1      <= '0;
                                color2      <= '0;
                                color1Valid <= 1'b0;
                                color2Valid <= 1'b0;
                                if (&new_matched) begin
                                    ledMask  <= '0;
                                    gameOver <= 1'b1;
                                    state    <= GAME_OVER;
                                end else begin
                                    ledMask <= new_matched;
                                    state   <= IDLE;
                                end
                            end else begin
                                rev_cnt  <= REV_LOAD;
                                mismatch <= 1'b1;
                                state    <= REVEAL;
                            end
                        end
                    end
                    REVEAL: begin
                        if (rev_cnt == '0) begin
                            idx1        <= '0;
                            idx2        <= '0;
                            color1      <= '0;
                            color2      <= '0;
                            color1Valid <= 1'b0;
                            color2Valid <= 1'b0;
                            mismatch    <= 1'b0;
                            ledMask     <= matchedMask;
                            state       <= IDLE;
                        end else begin
                            rev_cnt <= rev_cnt - CNT_W'(1);
                        end
                    end
                    GAME_OVER: begin
                        ledMask <= '0;
                    end
                    default: state <= NOT_IN_GAME;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_match_engine.sv
// tb_tile_match_engine: scoreboard bench for tile_match_engine.
// Two instances (SCORE_W=8 and SCORE_W=2) share all inputs.
module tb_tile_match_engine;

    localparam int N = 10;
    localparam int CW = 3;
    localparam int R = 4;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic            inGameOn;
    logic            userquit;
    logic            selectSW;
    logic [N-1:0]    SW;
    logic [N*CW-1:0] tileColors;

    logic [N-1:0]    ledMask, matchedMask;
    logic [CW-1:0]   color1, color2;
    logic            color1Valid, color2Valid, mismatch, gameOver;
    logic [7:0]      moves;

    logic [N-1:0]    ledMask2, matchedMask2;
    logic [CW-1:0]   color1_2, color2_2;
    logic            color1Valid2, color2Valid2, mismatch2, gameOver2;
    logic [1:0]      moves2;

    tile_match_engine #(.NUM_TILES(N), .COLOR_W(CW), .SCORE_W(8),
                        .REVEAL_CYCLES(R)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .inGameOn(inGameOn),
        .userquit(userquit), .selectSW(selectSW), .SW(SW),
        .tileColors(tileColors), .ledMask(ledMask),
        .matchedMask(matchedMask), .color1(color1), .color2(color2),
        .color1Valid(color1Valid), .color2Valid(color2Valid),
        .mismatch(mismatch), .moves(moves), .gameOver(gameOver));

    tile_match_engine #(.NUM_TILES(N), .COLOR_W(CW), .SCORE_W(2),
                        .REVEAL_CYCLES(R)) dut2 (
        .CLOCK_50(CLOCK_50), .reset(reset), .inGameOn(inGameOn),
        .userquit(userquit), .selectSW(selectSW), .SW(SW),
        .tileColors(tileColors), .ledMask(ledMask2),
        .matchedMask(matchedMask2), .color1(color1_2), .color2(color2_2),
        .color1Valid(color1Valid2), .color2Valid(color2Valid2),
        .mismatch(mismatch2), .moves(moves2), .gameOver(gameOver2));

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [N-1:0]  led;
        logic [N-1:0]  mm;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
        logic          v1;
        logic          v2;
        logic          mis;
        logic          go;
        logic [7:0]    mv;
        logic [1:0]    mv2;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                     $time);
        end
    endtask

    // ---------------- reference model (game-level) ----------------
    localparam int M_OFF = 0, M_IDLE = 1, M_ONE = 2, M_TWO = 3;
    localparam int M_REV = 4, M_OVER = 5;

    int          m_st = M_OFF;
    logic [N-1:0] m_matched = '0;
    int          m_p1 = 0, m_p2 = 0;
    bit          m_v1 = 0, m_v2 = 0;
    int          m_moves = 0;
    int          m_rem = 0;
    logic [N*CW-1:0] m_tab = '0;
    bit          h1 = 0, h2 = 0;

    function automatic int col(int p);
        return int'(m_tab[p*CW +: CW]);
    endfunction

    function automatic int find_pick(logic [N-1:0] sw, bit excl);
        for (int i = 0; i < N; i++)
            if (sw[i] && !m_matched[i] && !(excl && i == m_p1))
                return i;
        return -1;
    endfunction

    task automatic m_clear();
        m_st = M_OFF;
        m_matched = '0;
        m_moves = 0;
        m_v1 = 0;
        m_v2 = 0;
        m_rem = 0;
    endtask

    task automatic model_edge();
        bit sel;
        int p;
        sel = h2 & ~h1;
        h2 = h1;
        h1 = selectSW;
        if (reset) begin
            m_clear();
            m_tab = '0;
            h1 = 0;
            h2 = 0;
            return;
        end
        if (m_st != M_OFF && (userquit || !inGameOn)) begin
            m_clear();
            return;
        end
        case (m_st)
            M_OFF: if (inGameOn) begin
                m_tab = tileColors;
                m_matched = '0;
                m_moves = 0;
                m_st = M_IDLE;
            end
            M_IDLE: if (sel) begin
                p = find_pick(SW, 0);
                if (p >= 0) begin
                    m_p1 = p; m_v1 = 1; m_st = M_ONE;
                end
            end
            M_ONE: if (sel) begin
                p = find_pick(SW, 1);
                if (p >= 0) begin
                    m_p2 = p; m_v2 = 1; m_st = M_TWO;
                end
            end
            M_TWO: if (sel) begin
                m_moves++;
                if (col(m_p1) == col(m_p2)) begin
                    m_matched[m_p1] = 1'b1;
                    m_matched[m_p2] = 1'b1;
                    m_v1 = 0;
                    m_v2 = 0;
                    m_st = (&m_matched) ? M_OVER : M_IDLE;
                end else begin
                    m_rem = R;
                    m_st = M_REV;
                end
            end
            M_REV: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_v1 = 0; m_v2 = 0; m_st = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t expected();
        exp_t e;
        logic [N-1:0] one;
        one = 1;
        e.mm  = m_matched;
        e.led = m_matched;
        if (m_v1) e.led = e.led | (one << m_p1);
        if (m_v2) e.led = e.led | (one << m_p2);
        if (m_st == M_OVER) e.led = '0;
        e.v1  = m_v1;
        e.v2  = m_v2;
        e.c1  = m_v1 ? CW'(col(m_p1)) : '0;
        e.c2  = m_v2 ? CW'(col(m_p2)) : '0;
        e.mis = (m_st == M_REV);
        e.go  = (m_st == M_OVER);
        e.mv  = (m_moves > 255) ? 8'd255 : 8'(m_moves);
        e.mv2 = (m_moves > 3) ? 2'd3 : 2'(m_moves);
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ledMask", int'(ledMask), int'(e.led));
            chk("matchedMask", int'(matchedMask), int'(e.mm));
            chk("color1", int'(color1), int'(e.c1));
            chk("color2", int'(color2), int'(e.c2));
            chk("color1Valid", int'(color1Valid), int'(e.v1));
            chk("color2Valid", int'(color2Valid), int'(e.v2));
            chk("mismatch", int'(mismatch), int'(e.mis));
            chk("gameOver", int'(gameOver), int'(e.go));
            chk("moves", int'(moves), int'(e.mv));
            chk("moves_w2", int'(moves2), int'(e.mv2));
            chk("ledMask_w2", int'(ledMask2), int'(e.led));
            chk("mismatch_w2", int'(mismatch2), int'(e.mis));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge();
        q.push_back(expected());
        #1;
    endtask

    task automatic press();
        selectSW = 1'b1;
        cycle();
        selectSW = 1'b0;
        cycle();
        cycle();
        selectSW = 1'b1;
    endtask

    task automatic pick(int i);
        SW = '0;
        SW[i] = 1'b1;
        press();
    endtask

    task automatic wait_reveal();
        for (int k = 0; k < 20 && mismatch; k++)
            cycle();
        chk("reveal_ends", int'(mismatch), 0);
    endtask

    task automatic attempt(int a, int b);
        pick(a);
        pick(b);
        press();
    endtask

    task automatic async_reset_check();
        @(negedge CLOCK_50);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_ledMask", int'(ledMask), 0);
        chk("rst_color1Valid", int'(color1Valid), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_moves", int'(moves), 0);
        chk("rst_moves_w2", int'(moves2), 0);
        chk("rst_matchedMask", int'(matchedMask), 0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int cols[N] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};
        int n;
        reset = 1'b1;
        inGameOn = 1'b0;
        userquit = 1'b0;
        selectSW = 1'b1;
        SW = '0;
        for (int i = 0; i < N; i++)
            tileColors[i*CW +: CW] = CW'(cols[i]);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // match 0 and 7
        inGameOn = 1'b1;
        cycle();
        pick(0);
        pick(7);
        press();
        chk("t1_matched", int'(matchedMask), 'h081);
        chk("t1_moves", int'(moves), 1);
        chk("t1_led", int'(ledMask), 'h081);

        // invalid pick, then valid pick of tile 1
        SW = 10'h081;
        press();
        chk("t3_nopick", int'(color1Valid), 0);
        chk("t3_led", int'(ledMask), 'h081);
        SW = 10'h083;
        press();
        chk("t3_pick1", int'(color1), 2);
        chk("t3_led1", int'(ledMask), 'h083);

        // mismatch 1 vs 2 with presses during reveal
        pick(2);
        press();
        chk("t2_mis", int'(mismatch), 1);
        chk("t2_led", int'(ledMask), 'h087);
        SW = '0;
        n = 1;
        for (int k = 0; k < 12; k++) begin
            selectSW = k[0];
            cycle();
            if (mismatch) n++;
            else break;
        end
        selectSW = 1'b1;
        chk("t2_reveal_len", n, R);
        chk("t2_moves", int'(moves), 2);
        chk("t2_led_after", int'(ledMask), 'h081);

        // full game
        inGameOn = 1'b0;
        cycle();
        inGameOn = 1'b1;
        cycle();
        attempt(0, 7);
        attempt(1, 4);
        attempt(2, 6);
        attempt(3, 5);
        attempt(8, 9);
        chk("t4_gameOver", int'(gameOver), 1);
        chk("t4_moves", int'(moves), 5);
        chk("t4_led", int'(ledMask), 0);
        inGameOn = 1'b0;
        cycle();
        chk("t4_off_go", int'(gameOver), 0);
        chk("t4_off_mm", int'(matchedMask), 0);

        // abort from ONE_TILE
        inGameOn = 1'b1;
        cycle();
        attempt(0, 1);
        wait_reveal();
        pick(3);
        chk("t5_v1", int'(color1Valid), 1);
        userquit = 1'b1;
        cycle();
        chk("t5_v1_off", int'(color1Valid), 0);
        chk("t5_moves", int'(moves), 0);
        userquit = 1'b0;
        cycle();

        // saturation and reset mid-reveal
        for (int a = 0; a < 5; a++) begin
            attempt(0, 1);
            wait_reveal();
        end
        chk("t6_moves_w2", int'(moves2), 3);
        chk("t6_moves", int'(moves), 5);
        attempt(0, 1);
        cycle();
        async_reset_check();

        // random play
        for (int c = 0; c < 1500; c++) begin
            inGameOn = ($urandom_range(0, 99) != 0);
            userquit = ($urandom_range(0, 199) == 0);
            selectSW = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                SW = '0;
                SW[$urandom_range(0, N - 1)] = 1'b1;
            end else begin
                SW = N'($urandom);
            end
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < N; i++)
                    tileColors[i*CW +: CW] = CW'($urandom_range(0, 3));
            cycle();
            if (c == 900) async_reset_check();
        end

        @(negedge CLOCK_50);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
